alu_3bit_bist: RTL and testbench

//  Self-test sequencer for the 3-bit ALU. It drives the ALU's operand/select

---
 rtl/alu_3bit_bist.sv | 119 +++++++++++
 tb/tb_alu_3bit_bist.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_3bit_bist.sv
// Built-in self-test sequencer for the 3-bit ALU.
// Sweeps every {sel,a,b} vector in ascending order, captures the ALU result
// and flags after a programmable settle time, and compacts each response into
// a 16-bit MISR (poly 0x1021). The final signature is compared to GOLDEN_SIG.
module alu_3bit_bist #(
  parameter int unsigned W          = 3,
  parameter int unsigned SEL_W      = 3,
  parameter int unsigned SETTLE     = 1,
  parameter logic [15:0] MISR_SEED  = 16'hFFFF,
  parameter logic [15:0] GOLDEN_SIG = 16'h0000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [W-1:0]         a,
  output logic [W-1:0]         b,
  output logic [SEL_W-1:0]     sel,
  input  logic [W-1:0]         result,
  input  logic                 carry_out,
  input  logic                 zero,
  input  logic                 equal,
  input  logic                 less_than,
  input  logic                 greater_than,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          signature,
  output logic [2*W+SEL_W:0]   vec_count
);

  localparam int unsigned IDX_W  = 2 * W + SEL_W;
  localparam int unsigned RESP_W = W + 5;
  localparam int unsigned CNT_W  = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [IDX_W:0]   VEC_FULL    = {1'b1, {IDX_W{1'b0}}};
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;
  logic [RESP_W-1:0] resp;
  logic [15:0]      sig_next;

  assign resp = {greater_than, less_than, equal, zero, carry_out, result};

  // Next MISR value: shift with conditional polynomial feedback, then fold in the response
  always_comb begin
    sig_next = {signature[14:0], 1'b0} ^ (signature[15] ? 16'h1021 : 16'h0000);
    sig_next = sig_next ^ 16'(resp);
  end

  // Sweep sequencer: drive vector, wait SETTLE cycles, capture and compact
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      idx       <= '0;
      cnt       <= '0;
      a         <= '0;
      b         <= '0;
      sel       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      signature <= '0;
      vec_count <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            idx       <= '0;
            signature <= MISR_SEED;
            vec_count <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          {sel, a, b} <= idx;
          cnt         <= '0;
          state       <= (SETTLE == 0) ? ST_CAPTURE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CAPTURE: begin
          signature <= sig_next;
          if (vec_count != VEC_FULL) begin
            vec_count <= vec_count + 1'b1;
          end
          if (idx == '1) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (sig_next == GOLDEN_SIG);
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_3bit_bist.sv
// Directed bench for alu_3bit_bist: three instances (SETTLE=1 with a golden
// ALU model, SETTLE=0 and SETTLE=3 with ALU inputs tied low).
module tb_alu_3bit_bist;

  // ALU reference: returns {gt,lt,eq,zero,carry,result}; mode 0 = all zero,
  // 1 = golden, 2 = golden with result bit0 flipped on (sel=2,a=5,b=3)
  function automatic logic [7:0] alu_resp(input logic [2:0] s, input logic [2:0] x,
                                          input logic [2:0] y, input int mode);
    logic [3:0] t;
    logic [7:0] r;
    t = '0;
    case (s)
      3'd0: t = {1'b0, x} + {1'b0, y};
      3'd1: t = {1'b0, x} - {1'b0, y};
      3'd2: t = {1'b0, x & y};
      3'd3: t = {1'b0, x | y};
      3'd4: t = {1'b0, x ^ y};
      3'd5: t = {1'b0, ~x};
      3'd6: t = {x, 1'b0};
      default: t = {x[0], 1'b0, x[2:1]};
    endcase
    r = {x > y, x < y, x == y, t[2:0] == 3'd0, t[3], t[2:0]};
    if (mode == 2 && s == 3'd2 && x == 3'd5 && y == 3'd3) r = r ^ 8'h01;
    if (mode == 0) r = 8'h00;
    return r;
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] r);
    return ({s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000)) ^ {8'h00, r};
  endfunction

  function automatic logic [15:0] misr_run(input int mode);
    logic [15:0] s;
    logic [8:0]  v;
    s = 16'hFFFF;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      s = misr_step(s, alu_resp(v[8:6], v[5:3], v[2:0], mode));
    end
    return s;
  endfunction

  localparam logic [15:0] GOLD = misr_run(1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_v [3];
  logic [2:0]  a_v [3];
  logic [2:0]  b_v [3];
  logic [2:0]  sel_v [3];
  logic        busy_v [3];
  logic        done_v [3];
  logic        pass_v [3];
  logic [15:0] sig_v [3];
  logic [9:0]  cnt_v [3];

  logic [2:0]  res0;
  logic        co0, zr0, eq0, lt0, gt0;
  int          alu_mode = 0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // ALU under test for the main instance
  always_comb {gt0, lt0, eq0, zr0, co0, res0} = alu_resp(sel_v[0], a_v[0], b_v[0], alu_mode);

  alu_3bit_bist #(.SETTLE(1), .GOLDEN_SIG(GOLD)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .a(a_v[0]), .b(b_v[0]), .sel(sel_v[0]),
    .result(res0), .carry_out(co0), .zero(zr0), .equal(eq0),
    .less_than(lt0), .greater_than(gt0),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .signature(sig_v[0]), .vec_count(cnt_v[0])
  );

  alu_3bit_bist #(.SETTLE(0)) dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .a(a_v[1]), .b(b_v[1]), .sel(sel_v[1]),
    .result(3'd0), .carry_out(1'b0), .zero(1'b0), .equal(1'b0),
    .less_than(1'b0), .greater_than(1'b0),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .signature(sig_v[1]), .vec_count(cnt_v[1])
  );

  alu_3bit_bist #(.SETTLE(3)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]),
    .a(a_v[2]), .b(b_v[2]), .sel(sel_v[2]),
    .result(3'd0), .carry_out(1'b0), .zero(1'b0), .equal(1'b0),
    .less_than(1'b0), .greater_than(1'b0),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .signature(sig_v[2]), .vec_count(cnt_v[2])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input int d);
    check("rst_a",    32'(a_v[d]),    32'd0);
    check("rst_b",    32'(b_v[d]),    32'd0);
    check("rst_sel",  32'(sel_v[d]),  32'd0);
    check("rst_busy", 32'(busy_v[d]), 32'd0);
    check("rst_done", 32'(done_v[d]), 32'd0);
    check("rst_pass", 32'(pass_v[d]), 32'd0);
    check("rst_sig",  32'(sig_v[d]),  32'd0);
    check("rst_cnt",  32'(cnt_v[d]),  32'd0);
  endtask

  // One sweep on instance d; optional stray start pulse and mid-sweep reset
  task automatic run(input int d, input int per, input int mode,
                     input int pulse_at, input int rst_at);
    int          n;
    int          lim;
    logic [15:0] msig;
    logic [15:0] gold;
    logic [8:0]  v;
    lim  = per * 512;
    msig = 16'hFFFF;
    gold = (d == 0) ? GOLD : 16'h0000;
    @(negedge clk);
    start_v[d] = 1'b1;
    @(posedge clk);
    #1;
    start_v[d] = 1'b0;
    check("start_busy", 32'(busy_v[d]), 32'd1);
    check("start_done", 32'(done_v[d]), 32'd0);
    check("start_pass", 32'(pass_v[d]), 32'd0);
    check("start_cnt",  32'(cnt_v[d]),  32'd0);
    check("start_sig",  32'(sig_v[d]),  32'hFFFF);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
      if (n == pulse_at)     start_v[d] = 1'b1;
      if (n == pulse_at + 1) start_v[d] = 1'b0;
      if (n <= lim) begin
        if (n % per == 0) begin
          v    = 9'(n / per - 1);
          msig = misr_step(msig, alu_resp(v[8:6], v[5:3], v[2:0], mode));
        end
        check("vector", 32'({sel_v[d], a_v[d], b_v[d]}), 32'((n - 1) / per));
        check("count",  32'(cnt_v[d]),  32'(n / per));
        check("busy",   32'(busy_v[d]), 32'(n < lim));
        check("done",   32'(done_v[d]), 32'(n == lim));
        check("sig",    32'(sig_v[d]),  32'(msig));
      end
      if (n == rst_at) begin
        #2 rst = 1'b1;
        #1 chk_zero(d);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
    end while (done_v[d] !== 1'b1 && n < lim + 20);
    check("done_time", 32'(n), 32'(lim));
    check("pass", 32'(pass_v[d]), 32'(msig == gold));
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", 32'(done_v[d]), 32'd1);
    check("hold_cnt",  32'(cnt_v[d]),  32'd512);
    check("hold_vec",  32'({sel_v[d], a_v[d], b_v[d]}), 32'd511);
    check("hold_sig",  32'(sig_v[d]),  32'(msig));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 3; d++) start_v[d] = 1'b0;

    // Asynchronous reset before any clock edge, then idle with start low
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) chk_zero(d);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_busy", 32'(busy_v[0]), 32'd0);
      check("idle_done", 32'(done_v[0]), 32'd0);
      check("idle_vec",  32'({sel_v[0], a_v[0], b_v[0]}), 32'd0);
    end

    // Sweep with ALU inputs held at zero
    alu_mode = 0;
    run(0, 3, 0, 0, 0);
    check("zero_sig", 32'(sig_v[0]), 32'(misr_run(0)));

    // Golden ALU gives pass, single-bit fault gives fail
    alu_mode = 1;
    run(0, 3, 1, 0, 0);
    check("golden_pass", 32'(pass_v[0]), 32'd1);
    alu_mode = 2;
    run(0, 3, 2, 0, 0);
    check("fault_sig",  32'(sig_v[0]),  32'(misr_run(2)));
    check("fault_pass", 32'(pass_v[0]), 32'd0);

    // Stray start at vector 40 is ignored
    alu_mode = 0;
    run(0, 3, 0, 3 * 40 + 1, 0);

    // Reset at vector 100, then a clean restart
    run(0, 3, 0, 0, 3 * 100 + 1);
    check("abort_state", 32'(busy_v[0]), 32'd0);
    run(0, 3, 0, 0, 0);
    check("restart_sig", 32'(sig_v[0]), 32'(misr_run(0)));

    // Settle-time variants
    run(1, 2, 0, 0, 0);
    run(2, 5, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
